hssl_rx_frame_decoder: RTL and testbench
========================================

# hssl_rx_frame_decoder

Receive-side link layer for the HSSL between the Zynq board and the SpiNN-5 board. It consumes the 32-bit 8b/10b-decoded word stream and per-byte status from the GT receiver, in the rx_usrclk2 domain. It maintains link synchronisation and parses SOF/payload/EOF frames. Validated frames are delivered through a store-and-forward FIFO as a valid/ready word stream; corrupt or malformed frames are discarded whole.

## Interface
- ADDR_W, 5: FIFO address width. Depth is 2**ADDR_W words, each 32 data bits plus a last flag.
- SYNC_CNT, 4: consecutive clean IDLE words required to enter SYNC.
- ERR_LIMIT, 3: consecutive error words that force loss of sync.
- clk_in  in  1  rx_usrclk2; the only clock.
- reset_in  in  1  asynchronous, active-high reset.
- rx_reset_done_in  in  1  GT rx reset done. While low, the block is held in LOS.
- rx_data_in  in  32  received word; byte 0 is bits [7:0].
- rx_charisk_in  in  4  per-byte K flag.
- rx_disperr_in  in  4  per-byte disparity error.
- rx_encerr_in  in  4  per-byte not-in-table error.
- pkt_data_out  out  32  payload word.
- pkt_last_out  out  1  marks the final word of a frame.
- pkt_vld_out  out  1  output word valid.
- pkt_rdy_in  in  1  downstream ready.
- link_up_out  out  1  high in SYNC.
- frame_cnt_out  out  16  good frames committed; saturating.
- drop_cnt_out  out  16  frames dropped; saturating.

## Operation
- Word classes, decoded from byte 0 with rx_charisk_in == 4'b0001:
  - IDLE: byte 0 is 8'hBC.
  - SOF: byte 0 is 8'hFB, with length L in bits [15:8].
  - EOF: byte 0 is 8'hFD.
  - DATA: rx_charisk_in == 4'b0000.
  - Anything else is BADK.
- An error word is one where |rx_disperr_in or |rx_encerr_in is set.
- Sync FSM:
  - LOS to SYNC after SYNC_CNT consecutive error-free IDLE words.
  - SYNC to LOS after ERR_LIMIT consecutive error words, or immediately when rx_reset_done_in goes low.
  - A non-error word in SYNC clears the error run.
- Frame FSM (HUNT, PAYLOAD, EXPECT_EOF) runs only in SYNC. In LOS it is forced to HUNT.
- HUNT:
  - An SOF with L != 0 records the length, sets the tentative write pointer equal to the commit pointer, and moves to PAYLOAD.
  - An SOF with L == 0 counts as a drop and stays in HUNT.
  - All other words are ignored.
- PAYLOAD:
  - Each DATA word is written tentatively.
  - After L words, go to EXPECT_EOF. The L-th word is written with last set.
  - IDLE words are tolerated and not written.
- EXPECT_EOF:
  - A valid EOF commits: the commit pointer takes the write pointer, frame_cnt_out increments, and the FSM returns to HUNT.
  - Any other word is a drop.
- Drop, from PAYLOAD or EXPECT_EOF, on any of:
  - an error word
  - BADK, SOF or EOF in PAYLOAD
  - a non-EOF word in EXPECT_EOF
  - FIFO full on a write
  - loss of sync
- Drop action: the write pointer rewinds to the commit pointer, drop_cnt_out increments, and the FSM returns to HUNT. An SOF that triggers the drop is not reused as a new frame.
- Frame length limit: a frame with L > 2**ADDR_W - 1 can never fit, so it is dropped on overflow.
- The read side sees only committed words. A word is popped when pkt_vld_out && pkt_rdy_in.
- Counters saturate at 16'hFFFF.

## Timing
- Reset values:
  - FSMs in LOS/HUNT, with pointers and counters at 0.
  - pkt_vld_out = 0, pkt_last_out = 0, pkt_data_out = 0.
  - link_up_out = 0, frame_cnt_out = 0, drop_cnt_out = 0.
- Inputs are registered once; the FSMs act on the registered word.
- link_up_out rises 2 cycles after the edge that samples the SYNC_CNT-th IDLE, and falls with the same latency.
- The first payload word reaches the output 3 cycles after the edge sampling EOF, provided the output was empty. The output register is then back-to-back: 1 word per cycle while pkt_rdy_in is high.
- pkt_data_out and pkt_last_out are held stable while pkt_vld_out is high and pkt_rdy_in is low.
- If a commit and a pop occur in the same cycle, both take effect.
- Full is computed against the read pointer, not against the commit pointer.
- Counters update 1 cycle after the deciding input edge.
- Reset mid-frame: everything clears and uncommitted data is lost. Committed but unread words are also lost.

## Configuration
- HSSL_RX_CHKSUM_EN defined:
  - EOF bits [15:8] must equal the XOR of all 4L payload bytes.
  - A mismatch drops the frame.
- HSSL_RX_CHKSUM_EN undefined:
  - EOF bits [31:8] are ignored.
  - No checksum logic is present.

## Test plan
- Sync acquisition and loss:
  - 3 IDLEs leave link_up_out = 0; a 4th asserts it.
  - 3 consecutive words with rx_encerr_in = 4'b0100 deassert it.
  - 2 error words followed by a clean one keep it high.
- Good frame:
  - Stimulus: SOF with L = 3, DATA 32'h11111111, 32'h22222222, 32'h33333333, then EOF (with a correct checksum when the macro is on).
  - Response: three words out, last set on 32'h33333333, and frame_cnt_out = 1.
- Corruption mid-frame:
  - Stimulus: SOF L = 4, with disperr on the 2nd DATA word.
  - Response: nothing output, drop_cnt_out = 1.
  - A following good L = 1 frame is delivered intact.
- Overflow: with ADDR_W = 5 and pkt_rdy_in = 0, send SOF L = 40 and its data.
  - Response: drop_cnt_out = 1, no output.
  - A later L = 31 frame fills the FIFO exactly and commits.
- Backpressure and mixed events:
  - Stimulus: two L = 2 frames back-to-back, with pkt_rdy_in toggling 1010…
  - Response: 4 words in order, data stable while stalled, and a commit coinciding with a pop loses no word.
- Malformed and missing frames:
  - SOF L = 0: drop_cnt_out increments.
  - rx_reset_done_in dropped mid-frame: link_up_out falls, the frame is dropped, and the FSM re-syncs after 4 IDLEs.

Source files
------------

// File: rtl/hssl_rx_frame_decoder.sv
// hssl_rx_frame_decoder
// Receive-side HSSL link layer. Registers the GT word stream once, tracks
// link sync (LOS/SYNC), parses SOF/payload/EOF frames into a store-and-forward
// FIFO and delivers committed frames as a valid/ready word stream. Frames that
// are corrupt, malformed or too long are rewound and discarded whole.
// Optional feature macro: HSSL_RX_CHKSUM_EN (EOF carries an XOR checksum).
//
// Output handshake: a word transfers on every clk_in edge where pkt_vld_out
// and pkt_rdy_in are both high. While pkt_vld_out is high and pkt_rdy_in is
// low, pkt_vld_out stays high and pkt_data_out/pkt_last_out do not change.
module hssl_rx_frame_decoder #(
  parameter int ADDR_W    = 5,
  parameter int SYNC_CNT  = 4,
  parameter int ERR_LIMIT = 3
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        rx_reset_done_in,
  input  logic [31:0] rx_data_in,
  input  logic [3:0]  rx_charisk_in,
  input  logic [3:0]  rx_disperr_in,
  input  logic [3:0]  rx_encerr_in,
  output logic [31:0] pkt_data_out,
  output logic        pkt_last_out,
  output logic        pkt_vld_out,
  input  logic        pkt_rdy_in,
  output logic        link_up_out,
  output logic [15:0] frame_cnt_out,
  output logic [15:0] drop_cnt_out
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {SYNC_LOS, SYNC_UP} sync_e;
  typedef enum logic [1:0] {FR_HUNT, FR_PAYLOAD, FR_EXPECT_EOF} frame_e;

  // Registered copy of the receiver word
  logic [31:0] data_q;
  logic [3:0]  isk_q, derr_q, eerr_q;
  logic        rdone_q;

  // Register the GT receiver outputs once; everything downstream uses these
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      data_q  <= '0;
      isk_q   <= '0;
      derr_q  <= '0;
      eerr_q  <= '0;
      rdone_q <= 1'b0;
    end else begin
      data_q  <= rx_data_in;
      isk_q   <= rx_charisk_in;
      derr_q  <= rx_disperr_in;
      eerr_q  <= rx_encerr_in;
      rdone_q <= rx_reset_done_in;
    end
  end

  // Word classification from byte 0 and the K flags
  logic w_k0, w_idle, w_sof, w_eof, w_data, w_err;
  assign w_k0   = (isk_q == 4'b0001);
  assign w_idle = w_k0 && (data_q[7:0] == 8'hBC);
  assign w_sof  = w_k0 && (data_q[7:0] == 8'hFB);
  assign w_eof  = w_k0 && (data_q[7:0] == 8'hFD);
  assign w_data = (isk_q == 4'b0000);
  assign w_err  = (|derr_q) || (|eerr_q);

  // ---------------- sync FSM ----------------
  sync_e      sync_q, sync_d;
  logic [7:0] idle_run_q, idle_run_d, err_run_q, err_run_d;
  logic       link_up_q, link_up_d;

  // Next sync state: count clean IDLEs in LOS, error runs in SYNC
  always_comb begin
    sync_d     = sync_q;
    idle_run_d = idle_run_q;
    err_run_d  = err_run_q;
    link_up_d  = (sync_q == SYNC_UP);
    if (!rdone_q) begin
      sync_d     = SYNC_LOS;
      idle_run_d = '0;
      err_run_d  = '0;
    end else if (sync_q == SYNC_LOS) begin
      if (w_idle && !w_err) begin
        if (idle_run_q == 8'(SYNC_CNT - 1)) begin
          sync_d     = SYNC_UP;
          idle_run_d = '0;
          err_run_d  = '0;
        end else begin
          idle_run_d = idle_run_q + 8'd1;
        end
      end else begin
        idle_run_d = '0;
      end
    end else begin
      if (w_err) begin
        if (err_run_q == 8'(ERR_LIMIT - 1)) begin
          sync_d     = SYNC_LOS;
          err_run_d  = '0;
          idle_run_d = '0;
        end else begin
          err_run_d = err_run_q + 8'd1;
        end
      end else begin
        err_run_d = '0;
      end
    end
  end

  // Sync state registers; link_up lags the state by one cycle
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      sync_q     <= SYNC_LOS;
      idle_run_q <= '0;
      err_run_q  <= '0;
      link_up_q  <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      idle_run_q <= idle_run_d;
      err_run_q  <= err_run_d;
      link_up_q  <= link_up_d;
    end
  end

  // ---------------- frame FSM and write side ----------------
  frame_e              frame_q, frame_d;
  logic [7:0]          len_q, len_d, cnt_q, cnt_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d, cmt_ptr_q, cmt_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [15:0]         frame_cnt_q, frame_cnt_d, drop_cnt_q, drop_cnt_d;
  logic                wr_en, wr_last, drop, commit, zero_len, full, chk_ok;
  logic [32:0]         fifo_mem_q [DEPTH];

  // Full is judged against the read pointer; one slot stays empty
  assign full = ((wr_ptr_q + ADDR_W'(1)) == rd_ptr_q);

`ifdef HSSL_RX_CHKSUM_EN
  logic [7:0] chk_q, chk_d;
  assign chk_ok = (data_q[15:8] == chk_q);
`else
  assign chk_ok = 1'b1;
`endif

  // Next frame state: tentative writes, commit on EOF, rewind on any fault
  always_comb begin
    frame_d     = frame_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    wr_ptr_d    = wr_ptr_q;
    cmt_ptr_d   = cmt_ptr_q;
    frame_cnt_d = frame_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    wr_en       = 1'b0;
    wr_last     = 1'b0;
    drop        = 1'b0;
    commit      = 1'b0;
    zero_len    = 1'b0;
`ifdef HSSL_RX_CHKSUM_EN
    chk_d       = chk_q;
`endif
    if (sync_q != SYNC_UP) begin
      drop    = (frame_q != FR_HUNT);
      frame_d = FR_HUNT;
    end else begin
      case (frame_q)
        FR_HUNT: begin
          if (w_sof && !w_err) begin
            if (data_q[15:8] == 8'd0) begin
              zero_len = 1'b1;
            end else begin
              len_d    = data_q[15:8];
              cnt_d    = '0;
              wr_ptr_d = cmt_ptr_q;
              frame_d  = FR_PAYLOAD;
`ifdef HSSL_RX_CHKSUM_EN
              chk_d    = '0;
`endif
            end
          end
        end
        FR_PAYLOAD: begin
          if (w_err) begin
            drop = 1'b1;
          end else if (w_data) begin
            if (full) begin
              drop = 1'b1;
            end else begin
              wr_en    = 1'b1;
              wr_ptr_d = wr_ptr_q + ADDR_W'(1);
              cnt_d    = cnt_q + 8'd1;
`ifdef HSSL_RX_CHKSUM_EN
              chk_d    = chk_q ^ data_q[31:24] ^ data_q[23:16] ^ data_q[15:8] ^ data_q[7:0];
`endif
              if (cnt_q + 8'd1 == len_q) begin
                wr_last = 1'b1;
                frame_d = FR_EXPECT_EOF;
              end
            end
          end else if (!w_idle) begin
            drop = 1'b1;
          end
        end
        FR_EXPECT_EOF: begin
          if (w_eof && !w_err && chk_ok) commit = 1'b1;
          else                           drop   = 1'b1;
        end
        default: frame_d = FR_HUNT;
      endcase
    end
    if (drop) begin
      wr_ptr_d = cmt_ptr_q;
      frame_d  = FR_HUNT;
    end
    if (commit) begin
      cmt_ptr_d = wr_ptr_q;
      frame_d   = FR_HUNT;
      if (frame_cnt_q != 16'hFFFF) frame_cnt_d = frame_cnt_q + 16'd1;
    end
    if ((drop || zero_len) && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  // Frame state, pointers and counters
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      frame_q     <= FR_HUNT;
      len_q       <= '0;
      cnt_q       <= '0;
      wr_ptr_q    <= '0;
      cmt_ptr_q   <= '0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
`ifdef HSSL_RX_CHKSUM_EN
      chk_q       <= '0;
`endif
    end else begin
      frame_q     <= frame_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      cmt_ptr_q   <= cmt_ptr_d;
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
`ifdef HSSL_RX_CHKSUM_EN
      chk_q       <= chk_d;
`endif
    end
  end

  // FIFO storage: {last, data}; contents need no reset since pointers gate reads
  always_ff @(posedge clk_in) begin
    if (wr_en) fifo_mem_q[wr_ptr_q] <= {wr_last, data_q};
  end

  // ---------------- read side ----------------
  logic [ADDR_W-1:0] cmt_vis_q;
  logic [31:0]       out_data_q, out_data_d;
  logic              out_last_q, out_last_d, out_vld_q, out_vld_d, load;

  // Output register refills whenever it is empty or being popped
  assign load = (!out_vld_q || pkt_rdy_in) && (rd_ptr_q != cmt_vis_q);

  // Next read pointer and output register contents
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    out_data_d = out_data_q;
    out_last_d = out_last_q;
    out_vld_d  = out_vld_q;
    if (load) begin
      {out_last_d, out_data_d} = fifo_mem_q[rd_ptr_q];
      out_vld_d                = 1'b1;
      rd_ptr_d                 = rd_ptr_q + ADDR_W'(1);
    end else if (pkt_rdy_in) begin
      out_vld_d = 1'b0;
    end
  end

  // Read pointer, delayed commit pointer and output register
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      rd_ptr_q   <= '0;
      cmt_vis_q  <= '0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
      out_vld_q  <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      cmt_vis_q  <= cmt_ptr_q;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
      out_vld_q  <= out_vld_d;
    end
  end

  assign pkt_data_out  = out_data_q;
  assign pkt_last_out  = out_last_q;
  assign pkt_vld_out   = out_vld_q;
  assign link_up_out   = link_up_q;
  assign frame_cnt_out = frame_cnt_q;
  assign drop_cnt_out  = drop_cnt_q;

endmodule

// File: tb/tb_hssl_rx_frame_decoder.sv
// Testbench for hssl_rx_frame_decoder: directed sync/frame scenarios plus
// randomized frames, checked by a scoreboard queue and a frame-level model.
module tb_hssl_rx_frame_decoder;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 2 ** ADDR_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        rx_reset_done_in;
  logic [31:0] rx_data_in;
  logic [3:0]  rx_charisk_in, rx_disperr_in, rx_encerr_in;
  logic [31:0] pkt_data_out;
  logic        pkt_last_out, pkt_vld_out, pkt_rdy_in, link_up_out;
  logic [15:0] frame_cnt_out, drop_cnt_out;

  hssl_rx_frame_decoder #(.ADDR_W(ADDR_W), .SYNC_CNT(4), .ERR_LIMIT(3)) dut (
    .clk_in(clk), .reset_in(rst), .rx_reset_done_in(rx_reset_done_in),
    .rx_data_in(rx_data_in), .rx_charisk_in(rx_charisk_in),
    .rx_disperr_in(rx_disperr_in), .rx_encerr_in(rx_encerr_in),
    .pkt_data_out(pkt_data_out), .pkt_last_out(pkt_last_out),
    .pkt_vld_out(pkt_vld_out), .pkt_rdy_in(pkt_rdy_in),
    .link_up_out(link_up_out), .frame_cnt_out(frame_cnt_out),
    .drop_cnt_out(drop_cnt_out)
  );

  // ---------------- scoreboard state ----------------
  int          tests = 0;
  int          fails = 0;
  logic [32:0] exp_q[$];
  logic [31:0] pay_q[$];
  int          exp_frames = 0;
  int          exp_drops  = 0;
  int          rdy_mode   = 0;  // 0 always, 1 toggle, 2 random 3/4, 3 never

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // ---------------- ready driver ----------------
  initial begin
    pkt_rdy_in = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       pkt_rdy_in = 1'b1;
        1:       pkt_rdy_in = ~pkt_rdy_in;
        2:       pkt_rdy_in = ($urandom_range(0, 3) != 0);
        default: pkt_rdy_in = 1'b0;
      endcase
    end
  end

  // ---------------- monitor ----------------
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic        prev_last;
  logic [32:0] exp_word;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_hold", {31'b0, pkt_vld_out, pkt_last_out, pkt_data_out},
              {31'b0, 1'b1, prev_last, prev_data});
      end
      if (pkt_vld_out && pkt_rdy_in) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_word: got %0h, expected no output", pkt_data_out);
        end else begin
          exp_word = exp_q.pop_front();
          check("pop_word", 64'({pkt_last_out, pkt_data_out}), 64'(exp_word));
        end
      end
      prev_stall = pkt_vld_out && !pkt_rdy_in;
      prev_data  = pkt_data_out;
      prev_last  = pkt_last_out;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [31:0] d, input logic [3:0] k,
                       input logic [3:0] de, input logic [3:0] ee);
    rx_data_in    = d;
    rx_charisk_in = k;
    rx_disperr_in = de;
    rx_encerr_in  = ee;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    drive(32'h0000_00BC, 4'b0001, 4'h0, 4'h0);
  endtask

  task automatic idles(input int n);
    for (int i = 0; i < n; i++) idle();
  endtask

  task automatic err_idle();
    drive(32'h0000_00BC, 4'b0001, 4'h0, 4'b0100);
  endtask

  task automatic sof(input int len);
    drive({16'h0, 8'(len), 8'hFB}, 4'b0001, 4'h0, 4'h0);
  endtask

  task automatic eof(input logic [7:0] c);
    drive({16'h0, c, 8'hFD}, 4'b0001, 4'h0, 4'h0);
  endtask

  task automatic dat(input logic [31:0] d);
    drive(d, 4'b0000, 4'h0, 4'h0);
  endtask

  task automatic fill_random(input int len);
    pay_q.delete();
    for (int i = 0; i < len; i++) pay_q.push_back($urandom);
  endtask

  // Sends one frame from pay_q and predicts its fate from the frame rules.
  // corrupt: 0 clean, 1 error word at bad_pos, 2 K char at bad_pos,
  //          3 IDLE instead of EOF, 4 IDLE inserted before bad_pos (still good)
  task automatic send_frame(input int corrupt, input int bad_pos);
    int         len;
    logic [7:0] chk;
    bit         good;
    len  = pay_q.size();
    chk  = 8'h00;
    good = (corrupt == 0 || corrupt == 4) && len > 0 && len <= DEPTH - 1;
    sof(len);
    for (int i = 0; i < len; i++) begin
      if (corrupt == 4 && i == bad_pos) idle();
      if (corrupt == 1 && i == bad_pos)
        drive(pay_q[i], 4'b0000, 4'($urandom_range(1, 15)), 4'h0);
      else if (corrupt == 2 && i == bad_pos)
        drive(pay_q[i], 4'b0010, 4'h0, 4'h0);
      else
        dat(pay_q[i]);
      chk = chk ^ pay_q[i][31:24] ^ pay_q[i][23:16] ^ pay_q[i][15:8] ^ pay_q[i][7:0];
    end
    if (corrupt == 3) idle();
    else              eof(chk);
    if (good) begin
      for (int i = 0; i < len; i++) exp_q.push_back({(i == len - 1), pay_q[i]});
      exp_frames++;
    end else begin
      exp_drops++;
    end
  endtask

  task automatic check_counts(input string tag);
    idles(4);
    check({tag, "_frame_cnt"}, 64'(frame_cnt_out), 64'(exp_frames));
    check({tag, "_drop_cnt"},  64'(drop_cnt_out),  64'(exp_drops));
  endtask

  task automatic wait_drain(input string tag);
    int cyc;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 1000) begin
      idle();
      cyc++;
    end
    check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_room(input int len);
    int cyc;
    cyc = 0;
    while (exp_q.size() + len > 20 && cyc < 1000) begin
      idle();
      cyc++;
    end
    if (cyc >= 1000) check("room_wait", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    rx_reset_done_in = 1'b1;
    rx_data_in    = '0;
    rx_charisk_in = '0;
    rx_disperr_in = '0;
    rx_encerr_in  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_vld",   64'(pkt_vld_out),   64'd0);
    check("rst_last",  64'(pkt_last_out),  64'd0);
    check("rst_data",  64'(pkt_data_out),  64'd0);
    check("rst_link",  64'(link_up_out),   64'd0);
    check("rst_frame", 64'(frame_cnt_out), 64'd0);
    check("rst_drop",  64'(drop_cnt_out),  64'd0);
    rst = 1'b0;

    // Sync acquisition: 3 IDLEs are not enough, the 4th rises 2 cycles later
    idles(3);
    dat(32'h1234_5678); dat(32'h1234_5678); dat(32'h1234_5678);
    check("link_after_3_idles", 64'(link_up_out), 64'd0);
    idles(4);
    idle();
    check("link_rise_early", 64'(link_up_out), 64'd0);
    idle();
    check("link_rise", 64'(link_up_out), 64'd1);

    // Two error words then a clean one keep the link
    err_idle(); err_idle(); idle();
    idles(3);
    check("link_2err_hold", 64'(link_up_out), 64'd1);
    // Three error words drop it with the same latency
    err_idle(); err_idle(); err_idle();
    idle();
    check("link_fall_early", 64'(link_up_out), 64'd1);
    idle();
    check("link_fall", 64'(link_up_out), 64'd0);
    idles(6);
    check("link_resync", 64'(link_up_out), 64'd1);

    // Good frame L=3
    rdy_mode = 0;
    pay_q = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
    send_frame(0, 0);
    check_counts("good");
    wait_drain("good");

    // Corruption on 2nd DATA word, then a good L=1 frame
    fill_random(4);
    send_frame(1, 1);
    check_counts("corrupt");
    check("corrupt_no_out", 64'(pkt_vld_out), 64'd0);
    fill_random(1);
    send_frame(0, 0);
    check_counts("after_corrupt");
    wait_drain("after_corrupt");

    // Overflow with the output stalled, then an exactly-fitting frame
    rdy_mode = 3;
    idles(2);
    fill_random(40);
    send_frame(0, 0);
    check_counts("overflow");
    check("overflow_no_out", 64'(pkt_vld_out), 64'd0);
    fill_random(DEPTH - 1);
    send_frame(0, 0);
    check_counts("fit31");
    check("fit31_vld", 64'(pkt_vld_out), 64'd1);
    rdy_mode = 0;
    wait_drain("fit31");

    // Backpressure: two L=2 frames back-to-back with ready toggling
    rdy_mode = 1;
    fill_random(2);
    send_frame(0, 0);
    fill_random(2);
    send_frame(0, 0);
    wait_drain("toggle");
    check_counts("toggle");
    rdy_mode = 0;

    // SOF with L=0 counts as a drop
    pay_q.delete();
    send_frame(0, 0);
    check_counts("zero_len");

`ifdef HSSL_RX_CHKSUM_EN
    // Wrong checksum drops the frame
    sof(2);
    dat(32'h0102_0304);
    dat(32'h0000_0000);
    eof(8'h00);
    exp_drops++;
    check_counts("bad_chksum");
`endif

    // Receiver reset mid-frame: link falls, frame dropped, re-sync on IDLEs
    sof(4);
    dat(32'hAAAA_0001);
    dat(32'hAAAA_0002);
    rx_reset_done_in = 1'b0;
    dat(32'hAAAA_0003);
    idle();
    check("rdone_link_early", 64'(link_up_out), 64'd1);
    idle();
    check("rdone_link_fall", 64'(link_up_out), 64'd0);
    rx_reset_done_in = 1'b1;
    exp_drops++;
    dat(32'hAAAA_0004);
    idles(7);
    check("rdone_resync", 64'(link_up_out), 64'd1);
    check_counts("rdone");

    // Randomized frames with mixed faults and ready patterns
    for (int n = 0; n < 40; n++) begin
      int len, corrupt, pos;
      rdy_mode = $urandom_range(0, 2);
      len      = $urandom_range(1, 8);
      corrupt  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
      pos      = $urandom_range(0, len - 1);
      wait_room(len);
      fill_random(len);
      send_frame(corrupt, pos);
      if ($urandom_range(0, 1) == 1) idles($urandom_range(1, 3));
    end
    rdy_mode = 0;
    wait_drain("random");
    check_counts("random");
    check("final_link", 64'(link_up_out), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
